// File: rtl/display_state_controller.sv
// Debounced three-button front panel: centre button cycles display mode (short) or latches sw into the active slot (long).
// Up/down buttons select the slot; latched_value tracks the selected slot one cycle after any change.
module display_state_controller #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int SW_WIDTH        = 16,
    parameter int NUM_SLOTS       = 4,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100,
    parameter int LONG_CYCLES     = CLK_FREQ
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SW_WIDTH-1:0]          sw,
    input  logic                         btn_c,
    input  logic                         btn_u,
    input  logic                         btn_d,
    output logic [SW_WIDTH-1:0]          latched_value,
    output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
    output logic [1:0]                   display_mode,
    output logic [NUM_SLOTS-1:0]         slot_valid,
    output logic                         latch_pulse
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    // Bit 0 = centre, bit 1 = up, bit 2 = down.
    logic [2:0]      btn_raw;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [2:0]      deb;
    logic [2:0]      rise;
    logic            c_fall;
    logic [DB_W-1:0] db_cnt [3];

    assign btn_raw = {btn_d, btn_u, btn_c};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            rise   <= '0;
            c_fall <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            rise   <= '0;
            c_fall <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // Edge pulses are registered alongside the flip, so they show up the following cycle.
                    deb[i]    <= sync_b[i];
                    db_cnt[i] <= '0;
                    rise[i]   <= sync_b[i];
                    if (i == 0) begin
                        c_fall <= ~sync_b[i];
                    end
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    press_state_t      state;
    press_state_t      state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              short_evt;
    logic              long_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        short_evt    = 1'b0;
        long_evt     = 1'b0;
        case (state)
            IDLE: begin
                if (rise[0]) begin
                    state_nxt    = PRESSED;
                    hold_cnt_nxt = '0;
                end
            end
            PRESSED: begin
                // Release wins over a simultaneous threshold hit; the counter stops at the threshold.
                if (c_fall) begin
                    state_nxt = IDLE;
                    short_evt = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = LONG_HELD;
                    long_evt  = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                if (c_fall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [SW_WIDTH-1:0] slots [NUM_SLOTS];
    logic                step_up;
    logic                step_dn;

    assign step_up = rise[1] & ~rise[2];
    assign step_dn = rise[2] & ~rise[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
            latched_value <= '0;
            active_slot   <= '0;
            display_mode  <= 2'b00;
            slot_valid    <= '0;
            latch_pulse   <= 1'b0;
        end else begin
            latch_pulse <= long_evt;
            // Write uses the slot index from before any same-cycle navigation.
            if (long_evt) begin
                slots[active_slot]      <= sw;
                slot_valid[active_slot] <= 1'b1;
            end
            if (step_up) begin
                active_slot <= active_slot + SLOT_W'(1);
            end else if (step_dn) begin
                active_slot <= active_slot - SLOT_W'(1);
            end
            if (short_evt) begin
                display_mode <= display_mode + 2'd1;
            end
            latched_value <= slots[active_slot];
        end
    end

endmodule

// File: tb/tb_display_state_controller.sv
// Scoreboarded bench: expected slot writes and mode changes are queued by the stimulus tasks and
// popped by a monitor as the DUT produces latch pulses and mode transitions.
module tb_display_state_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sw = 16'h0000;
    logic        btn_c = 1'b0;
    logic        btn_u = 1'b0;
    logic        btn_d = 1'b0;
    logic [15:0] latched_value;
    logic [1:0]  active_slot;
    logic [1:0]  display_mode;
    logic [3:0]  slot_valid;
    logic        latch_pulse;

    display_state_controller #(
        .CLK_FREQ(1000),
        .SW_WIDTH(16),
        .NUM_SLOTS(4),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw(sw),
        .btn_c(btn_c),
        .btn_u(btn_u),
        .btn_d(btn_d),
        .latched_value(latched_value),
        .active_slot(active_slot),
        .display_mode(display_mode),
        .slot_valid(slot_valid),
        .latch_pulse(latch_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  slot;
        logic [15:0] value;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    wr_t         wr_q[$];
    logic [1:0]  mode_q[$];
    logic [15:0] mem [4];
    logic [3:0]  vmask = 4'b0000;
    logic [1:0]  cur_slot = 2'd0;
    logic [1:0]  cur_mode = 2'd0;
    logic [1:0]  prev_mode = 2'd0;
    logic        pend = 1'b0;
    logic [15:0] pend_val = 16'h0000;
    wr_t         mon_e;
    logic [1:0]  mon_m;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_mode = 2'd0;
            pend      = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                checks++;
                if (latched_value !== pend_val) begin
                    errors++;
                    $display("FAIL sb_latched_value: got %h expected %h", latched_value, pend_val);
                end
            end
            if (latch_pulse) begin
                pulses++;
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_latch: got pulse on slot %0d expected none", active_slot);
                end else begin
                    mon_e = wr_q.pop_front();
                    if (active_slot !== mon_e.slot || slot_valid[mon_e.slot] !== 1'b1) begin
                        errors++;
                        $display("FAIL sb_latch_slot: got slot %0d valid %b expected slot %0d valid set",
                                 active_slot, slot_valid, mon_e.slot);
                    end
                    pend     = 1'b1;
                    pend_val = mon_e.value;
                end
            end
            if (display_mode !== prev_mode) begin
                checks++;
                if (mode_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_mode: got %b expected %b", display_mode, prev_mode);
                end else begin
                    mon_m = mode_q.pop_front();
                    if (display_mode !== mon_m) begin
                        errors++;
                        $display("FAIL sb_mode: got %b expected %b", display_mode, mon_m);
                    end
                end
                prev_mode = display_mode;
            end
        end
    end

    task automatic press_c(input int hold);
        btn_c = 1'b1;
        cyc(hold);
        btn_c = 1'b0;
        cyc(30);
    endtask

    task automatic long_write(input logic [15:0] val);
        sw = val;
        wr_q.push_back('{slot: cur_slot, value: val});
        mem[cur_slot] = val;
        vmask[cur_slot] = 1'b1;
        press_c(40);
        sw = ~val;
    endtask

    task automatic press_ud(input bit up, input bit dn);
        btn_u = up;
        btn_d = dn;
        cyc(10);
        btn_u = 1'b0;
        btn_d = 1'b0;
        cyc(15);
        if (up && !dn) cur_slot = cur_slot + 2'd1;
        else if (dn && !up) cur_slot = cur_slot - 2'd1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        checks++;
        if (latched_value !== 16'h0) begin errors++; $display("FAIL reset_latched: got %h expected 0000", latched_value); end
        checks++;
        if (active_slot !== 2'd0) begin errors++; $display("FAIL reset_slot: got %0d expected 0", active_slot); end
        checks++;
        if (display_mode !== 2'b00) begin errors++; $display("FAIL reset_mode: got %b expected 00", display_mode); end
        checks++;
        if (slot_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", slot_valid); end
        checks++;
        if (latch_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", latch_pulse); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_long_press();
        int p0;
        p0 = pulses;
        sw = 16'hBEEF;
        wr_q.push_back('{slot: cur_slot, value: 16'hBEEF});
        mem[cur_slot] = 16'hBEEF;
        vmask[cur_slot] = 1'b1;
        btn_c = 1'b1;
        cyc(40);
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL long_while_held: got %0d pulses expected 1", pulses - p0); end
        btn_c = 1'b0;
        sw = 16'h0000;
        cyc(30);
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL long_single: got %0d pulses expected 1", pulses - p0); end
        checks++;
        if (latched_value !== 16'hBEEF) begin errors++; $display("FAIL long_value: got %h expected beef", latched_value); end
        checks++;
        if (slot_valid !== 4'b0001) begin errors++; $display("FAIL long_valid: got %b expected 0001", slot_valid); end
        checks++;
        if (display_mode !== 2'b00) begin errors++; $display("FAIL long_mode: got %b expected 00", display_mode); end
    endtask

    task automatic test_short_press();
        int p0;
        for (int i = 0; i < 4; i++) begin
            p0 = pulses;
            cur_mode = cur_mode + 2'd1;
            mode_q.push_back(cur_mode);
            press_c(10);
            checks++;
            if (display_mode !== cur_mode) begin errors++; $display("FAIL short_mode_%0d: got %b expected %b", i, display_mode, cur_mode); end
            checks++;
            if (pulses !== p0) begin errors++; $display("FAIL short_no_latch_%0d: got %0d pulses expected %0d", i, pulses, p0); end
        end
    endtask

    task automatic test_slot_nav();
        press_ud(1'b0, 1'b1);
        checks++;
        if (active_slot !== 2'd3) begin errors++; $display("FAIL nav_down_wrap: got %0d expected 3", active_slot); end
        checks++;
        if (latched_value !== mem[3]) begin errors++; $display("FAIL nav_view3: got %h expected %h", latched_value, mem[3]); end
        long_write(16'h3333);
        checks++;
        if (latched_value !== 16'h3333 || slot_valid !== vmask) begin
            errors++; $display("FAIL nav_write3: got %h/%b expected 3333/%b", latched_value, slot_valid, vmask);
        end
        press_ud(1'b1, 1'b0);
        checks++;
        if (active_slot !== 2'd0 || latched_value !== mem[0]) begin
            errors++; $display("FAIL nav_up_wrap: got %0d/%h expected 0/%h", active_slot, latched_value, mem[0]);
        end
        press_ud(1'b1, 1'b0);
        checks++;
        if (active_slot !== 2'd1 || latched_value !== mem[1]) begin
            errors++; $display("FAIL nav_up1: got %0d/%h expected 1/%h", active_slot, latched_value, mem[1]);
        end
    endtask

    task automatic test_rewrite();
        press_ud(1'b0, 1'b1);
        long_write(16'hCAFE);
        checks++;
        if (active_slot !== 2'd0 || latched_value !== 16'hCAFE || slot_valid !== 4'b1001) begin
            errors++; $display("FAIL rewrite: got %0d/%h/%b expected 0/cafe/1001", active_slot, latched_value, slot_valid);
        end
        press_ud(1'b0, 1'b1);
        checks++;
        if (latched_value !== 16'h3333) begin errors++; $display("FAIL retain3: got %h expected 3333", latched_value); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] s0;
        int         p0;
        s0 = cur_slot;
        press_ud(1'b1, 1'b1);
        checks++;
        if (active_slot !== s0) begin errors++; $display("FAIL updown_same_cycle: got %0d expected %0d", active_slot, s0); end
        p0 = pulses;
        btn_c = 1'b1;
        cyc(2);
        btn_c = 1'b0;
        cyc(30);
        checks++;
        if (display_mode !== cur_mode || pulses !== p0) begin
            errors++; $display("FAIL glitch: got mode %b pulses %0d expected %b %0d", display_mode, pulses, cur_mode, p0);
        end
    endtask

    task automatic test_reset_midpress();
        int p0;
        press_ud(1'b0, 1'b1);
        long_write(16'h1234);
        checks++;
        if (active_slot !== 2'd2 || latched_value !== 16'h1234) begin
            errors++; $display("FAIL slot2_write: got %0d/%h expected 2/1234", active_slot, latched_value);
        end
        press_ud(1'b1, 1'b0);
        press_ud(1'b1, 1'b0);
        checks++;
        if (active_slot !== 2'd0 || latched_value !== 16'hCAFE) begin
            errors++; $display("FAIL back_to_0: got %0d/%h expected 0/cafe", active_slot, latched_value);
        end
        p0 = pulses;
        sw = 16'hDEAD;
        btn_c = 1'b1;
        cyc(15);
        reset = 1'b1;
        cyc(2);
        btn_c = 1'b0;
        cyc(2);
        checks++;
        if (latched_value !== 16'h0 || active_slot !== 2'd0 || display_mode !== 2'b00 || slot_valid !== 4'b0 || latch_pulse !== 1'b0) begin
            errors++; $display("FAIL midpress_reset: got %h/%0d/%b/%b/%b expected all zero",
                               latched_value, active_slot, display_mode, slot_valid, latch_pulse);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 16'h0;
        vmask = 4'b0;
        cur_slot = 2'd0;
        cur_mode = 2'd0;
        cyc(40);
        checks++;
        if (pulses !== p0 || latched_value !== 16'h0) begin
            errors++; $display("FAIL midpress_no_event: got pulses %0d value %h expected %0d 0000", pulses, latched_value, p0);
        end
        press_ud(1'b1, 1'b0);
        press_ud(1'b1, 1'b0);
        checks++;
        if (active_slot !== 2'd2 || latched_value !== 16'h0 || slot_valid !== 4'b0) begin
            errors++; $display("FAIL slot2_cleared: got %0d/%h/%b expected 2/0000/0000", active_slot, latched_value, slot_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 16'h0;
        test_reset();
        test_long_press();
        test_short_press();
        test_slot_nav();
        test_rewrite();
        test_back_to_back();
        test_reset_midpress();
        checks++;
        if (wr_q.size() != 0 || mode_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d writes %0d modes outstanding expected 0 0", wr_q.size(), mode_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
